// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int DIV_MIN   = 2;

  // Divisors below DIV_MIN cannot produce a high and a low phase, so they saturate.
  function automatic int clamp_div(input int d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  // High-phase length ceil(N/2); odd divisors spend the extra cycle high.
  function automatic int half_div(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with a shadowed divisor that is applied
// only at a period boundary, so clk_out never shows a runt pulse.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_active,
  output logic             div_pending
);

  if (DEFAULT_DIV < DIV_MIN || DEFAULT_DIV > (2 ** CNT_W) - 1) begin : g_bad_default
    $error("clk_div_prog: DEFAULT_DIV out of range");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] div_in_clamped;
  logic             boundary;

  assign half           = CNT_W'(half_div(int'(div_act_q)));
  assign div_in_clamped = CNT_W'(clamp_div(int'(div_in)));
  assign boundary       = en && (cnt_q == div_act_q - CNT_W'(1));

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    div_act_d  = div_act_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;

    if (en) begin
      cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == '0) begin
        clk_d  = 1'b1;
        tick_d = 1'b1;
      end else if (cnt_q == half) begin
        clk_d = 1'b0;
      end
    end

    // A load landing on the boundary edge goes straight into effect.
    if (boundary && div_load) begin
      div_act_d = div_in_clamped;
      pend_d    = 1'b0;
    end else if (boundary && pend_q) begin
      div_act_d = pend_val_q;
      pend_d    = 1'b0;
    end else if (div_load) begin
      pend_val_d = div_in_clamped;
      pend_d     = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      div_act_q  <= CNT_W'(DEFAULT_DIV);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      div_act_q  <= div_act_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
    end
  end

  assign clk_out     = clk_q;
  assign tick        = tick_q;
  assign div_active  = div_act_q;
  assign div_pending = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog; expected waveforms are
// hand-derived bit patterns, one bit per clk_in edge, oldest edge first.
module tb_clk_div_prog;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] div_active;
  logic             div_pending;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(8)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .div_in      (div_in),
    .div_load    (div_load),
    .clk_out     (clk_out),
    .tick        (tick),
    .div_active  (div_active),
    .div_pending (div_pending)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic expect_seq(input string tag, input int n,
                            input logic [63:0] clk_exp, input logic [63:0] tick_exp);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s.clk[%0d]", tag, i), {31'd0, clk_out}, {31'd0, clk_exp[n-1-i]});
      check($sformatf("%s.tick[%0d]", tag, i), {31'd0, tick}, {31'd0, tick_exp[n-1-i]});
    end
  endtask

  task automatic check_div(input string tag, input int act, input logic pend);
    check({tag, ".div_active"}, {24'd0, div_active}, act[31:0]);
    check({tag, ".div_pending"}, {31'd0, div_pending}, {31'd0, pend});
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    div_in   = '0;
    div_load = 1'b0;
    repeat (10) step();
    check({"rst", ".clk"}, {31'd0, clk_out}, 32'd0);
    check({"rst", ".tick"}, {31'd0, tick}, 32'd0);
    check_div("rst", 8, 1'b0);
    rst = 1'b0;

    // Default N=8: 4 high, 4 low, tick on each rising edge.
    expect_seq("n8", 16, 64'b1111000011110000, 64'b1000000010000000);
    check_div("n8", 8, 1'b0);

    // Load 5 at cnt=2; current period finishes as N=8, then 3/2.
    expect_seq("ld5a", 2, 64'b11, 64'b10);
    div_load = 1'b1;
    div_in   = 8'd5;
    expect_seq("ld5b", 1, 64'b1, 64'b0);
    div_load = 1'b0;
    check_div("ld5b", 8, 1'b1);
    expect_seq("ld5c", 5, 64'b10000, 64'b00000);
    check_div("ld5c", 5, 1'b0);
    expect_seq("n5", 10, 64'b1110011100, 64'b1000010000);

    // Load 0 clamps to 2 at the boundary.
    div_load = 1'b1;
    div_in   = 8'd0;
    expect_seq("ld0a", 1, 64'b1, 64'b1);
    div_load = 1'b0;
    check_div("ld0a", 5, 1'b1);
    expect_seq("ld0b", 4, 64'b1100, 64'b0000);
    check_div("ld0b", 2, 1'b0);
    expect_seq("n2", 8, 64'b10101010, 64'b10101010);

    // Back to N=8, then freeze for 3 edges in the high phase.
    div_load = 1'b1;
    div_in   = 8'd8;
    expect_seq("ld8a", 1, 64'b1, 64'b1);
    div_load = 1'b0;
    expect_seq("ld8b", 1, 64'b0, 64'b0);
    check_div("ld8b", 8, 1'b0);
    expect_seq("frz_a", 2, 64'b11, 64'b10);
    en = 1'b0;
    expect_seq("frz_b", 3, 64'b111, 64'b000);
    en = 1'b1;
    expect_seq("frz_c", 6, 64'b110000, 64'b000000);

    // Load 6 exactly on the boundary edge: bypasses pending.
    expect_seq("bnd_a", 7, 64'b1111000, 64'b1000000);
    div_load = 1'b1;
    div_in   = 8'd6;
    expect_seq("bnd_b", 1, 64'b0, 64'b0);
    div_load = 1'b0;
    check_div("bnd_b", 6, 1'b0);
    expect_seq("n6", 6, 64'b111000, 64'b100000);

    // Reset mid high phase with a pending 12.
    div_load = 1'b1;
    div_in   = 8'd12;
    expect_seq("rst2a", 1, 64'b1, 64'b1);
    div_load = 1'b0;
    check_div("rst2a", 6, 1'b1);
    expect_seq("rst2b", 1, 64'b1, 64'b0);
    rst = 1'b1;
    expect_seq("rst2c", 1, 64'b0, 64'b0);
    check_div("rst2c", 8, 1'b0);
    rst = 1'b0;
    expect_seq("rst2d", 9, 64'b111100001, 64'b100000001);
    check_div("rst2d", 8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
